opex_register: RTL and testbench

OPEX_REGISTER -- requirements
Module: opex_register

---
 rtl/opex_register.sv | 203 ++++++++++++++++++++
 tb/tb_opex_register.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/opex_register.sv
// opex_register
// OP/EX pipeline register with late operand forwarding.
//
// The register sits between the operand-fetch (OP) stage and the execute
// (EX) stage. Operands may still be in flight when an instruction enters
// EX; the forwarding flags select the newest producer. Flag bit 0/1 selects
// the MA-stage result, and bit 2/3 selects the WB-stage result, for op1/op2.
//
// When EX stalls, the producers keep moving down the pipe. Their values
// would be lost, so every stalled edge captures the forwarded value into
// the operand register and clears the flags.
//
// Priority of the next-state update: flush > stall > bubble > load.
//
// Optional build macro:
//   OPEX_PARITY_EN  stores one even-parity bit per operand register and
//                   checks it every cycle. Without it s_par_err_o is tied
//                   low and no parity storage exists.

module opex_register (
   input  logic        s_clk_i,
   input  logic        s_resetn_i,

   input  logic [31:0] s_idop_op1_i,
   input  logic [31:0] s_idop_op2_i,
   input  logic [3:0]  s_idop_fwd_i,
   input  logic        s_idop_bubble_i,
   input  logic [4:0]  s_idop_rd_i,
   input  logic [3:0]  s_idop_f_i,
   input  logic [6:0]  s_idop_ictrl_i,
   input  logic [20:0] s_idop_payload_i,

   input  logic [31:0] s_exma_val_i,
   input  logic [31:0] s_mawb_val_i,
   input  logic        s_ex_stall_i,
   input  logic        s_flush_i,

   output logic [31:0] s_opex_op1_o,
   output logic [31:0] s_opex_op2_o,
   output logic [4:0]  s_opex_rd_o,
   output logic [3:0]  s_opex_f_o,
   output logic [6:0]  s_opex_ictrl_o,
   output logic [20:0] s_opex_payload_o,
   output logic [3:0]  s_opex_fwd_o,
   output logic        s_idop_hold_o,
   output logic [7:0]  s_stall_cnt_o,
   output logic        s_par_err_o
);

   localparam logic [7:0] STALL_CNT_MAX = 8'hFF;

   // Registered pipeline fields
   logic [31:0] op1_q;
   logic [31:0] op2_q;
   logic [3:0]  fwd_q;
   logic [4:0]  rd_q;
   logic [3:0]  f_q;
   logic [6:0]  ictrl_q;
   logic [20:0] payload_q;
   logic [7:0]  stall_cnt_q;

   // Next-state values
   logic [31:0] op1_d;
   logic [31:0] op2_d;
   logic [3:0]  fwd_d;
   logic [4:0]  rd_d;
   logic [3:0]  f_d;
   logic [6:0]  ictrl_d;
   logic [20:0] payload_d;
   logic [7:0]  stall_cnt_d;

   logic        slot_valid;
   logic [31:0] op1_fwd;
   logic [31:0] op2_fwd;

   // An all-zero control word marks the slot as empty (NOP).
   assign slot_valid = |ictrl_q;

   // Operand resolution: the MA-stage result is newer than the WB-stage
   // result, so it wins when both flags are set.
   always_comb begin
      op1_fwd = op1_q;
      if (fwd_q[0]) begin
         op1_fwd = s_exma_val_i;
      end else if (fwd_q[2]) begin
         op1_fwd = s_mawb_val_i;
      end

      op2_fwd = op2_q;
      if (fwd_q[1]) begin
         op2_fwd = s_exma_val_i;
      end else if (fwd_q[3]) begin
         op2_fwd = s_mawb_val_i;
      end
   end

   // Next-state selection for the pipeline fields.
   always_comb begin
      op1_d     = op1_q;
      op2_d     = op2_q;
      fwd_d     = fwd_q;
      rd_d      = rd_q;
      f_d       = f_q;
      ictrl_d   = ictrl_q;
      payload_d = payload_q;

      if (s_flush_i) begin
         // Kill the instruction; data fields are irrelevant once empty.
         ictrl_d = 7'd0;
         fwd_d   = 4'd0;
         rd_d    = 5'd0;
      end else if (s_ex_stall_i) begin
         // Hold, but pull in forwarded values before they leave MA/WB.
         // op*_fwd already equals the held register when no flag is set.
         op1_d = op1_fwd;
         op2_d = op2_fwd;
         fwd_d = 4'd0;
      end else begin
         op1_d     = s_idop_op1_i;
         op2_d     = s_idop_op2_i;
         f_d       = s_idop_f_i;
         payload_d = s_idop_payload_i;
         if (s_idop_bubble_i) begin
            ictrl_d = 7'd0;
            fwd_d   = 4'd0;
            rd_d    = 5'd0;
         end else begin
            ictrl_d = s_idop_ictrl_i;
            fwd_d   = s_idop_fwd_i;
            rd_d    = s_idop_rd_i;
         end
      end
   end

   // Stall counter: counts consecutive stalled edges of a live instruction,
   // saturating so a long stall never wraps back to a small value.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (s_flush_i || !s_ex_stall_i) begin
         stall_cnt_d = 8'd0;
      end else if (slot_valid && (stall_cnt_q != STALL_CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 8'd1;
      end
   end

   // Pipeline register; reset empties the slot and clears all data.
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         op1_q       <= 32'd0;
         op2_q       <= 32'd0;
         fwd_q       <= 4'd0;
         rd_q        <= 5'd0;
         f_q         <= 4'd0;
         ictrl_q     <= 7'd0;
         payload_q   <= 21'd0;
         stall_cnt_q <= 8'd0;
      end else begin
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         fwd_q       <= fwd_d;
         rd_q        <= rd_d;
         f_q         <= f_d;
         ictrl_q     <= ictrl_d;
         payload_q   <= payload_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

`ifdef OPEX_PARITY_EN
   logic par1_q;
   logic par2_q;

   // Parity follows every operand write, including stall captures.
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         par1_q <= 1'b0;
         par2_q <= 1'b0;
      end else begin
         par1_q <= ^op1_d;
         par2_q <= ^op2_d;
      end
   end

   // Re-check the stored operands every cycle; only live slots report.
   assign s_par_err_o = slot_valid & ((^op1_q ^ par1_q) | (^op2_q ^ par2_q));
`else
   assign s_par_err_o = 1'b0;
`endif

   assign s_opex_op1_o     = op1_fwd;
   assign s_opex_op2_o     = op2_fwd;
   assign s_opex_rd_o      = rd_q;
   assign s_opex_f_o       = f_q;
   assign s_opex_ictrl_o   = ictrl_q;
   assign s_opex_payload_o = payload_q;
   assign s_opex_fwd_o     = fwd_q;
   assign s_stall_cnt_o    = stall_cnt_q;

   // OP must keep its instruction whenever this stage does not take it,
   // unless the whole pipe is being flushed.
   assign s_idop_hold_o = (s_ex_stall_i | s_idop_bubble_i) & ~s_flush_i;

endmodule

// File: tb/tb_opex_register.sv
// tb_opex_register
// Directed vector bench for opex_register. Also builds with OPEX_PARITY_EN.

module tb_opex_register;

   logic        s_clk_i = 1'b0;
   logic        s_resetn_i;
   logic [31:0] s_idop_op1_i;
   logic [31:0] s_idop_op2_i;
   logic [3:0]  s_idop_fwd_i;
   logic        s_idop_bubble_i;
   logic [4:0]  s_idop_rd_i;
   logic [3:0]  s_idop_f_i;
   logic [6:0]  s_idop_ictrl_i;
   logic [20:0] s_idop_payload_i;
   logic [31:0] s_exma_val_i;
   logic [31:0] s_mawb_val_i;
   logic        s_ex_stall_i;
   logic        s_flush_i;
   logic [31:0] s_opex_op1_o;
   logic [31:0] s_opex_op2_o;
   logic [4:0]  s_opex_rd_o;
   logic [3:0]  s_opex_f_o;
   logic [6:0]  s_opex_ictrl_o;
   logic [20:0] s_opex_payload_o;
   logic [3:0]  s_opex_fwd_o;
   logic        s_idop_hold_o;
   logic [7:0]  s_stall_cnt_o;
   logic        s_par_err_o;

   int checks = 0;
   int errors = 0;

   opex_register dut (
      .s_clk_i          (s_clk_i),
      .s_resetn_i       (s_resetn_i),
      .s_idop_op1_i     (s_idop_op1_i),
      .s_idop_op2_i     (s_idop_op2_i),
      .s_idop_fwd_i     (s_idop_fwd_i),
      .s_idop_bubble_i  (s_idop_bubble_i),
      .s_idop_rd_i      (s_idop_rd_i),
      .s_idop_f_i       (s_idop_f_i),
      .s_idop_ictrl_i   (s_idop_ictrl_i),
      .s_idop_payload_i (s_idop_payload_i),
      .s_exma_val_i     (s_exma_val_i),
      .s_mawb_val_i     (s_mawb_val_i),
      .s_ex_stall_i     (s_ex_stall_i),
      .s_flush_i        (s_flush_i),
      .s_opex_op1_o     (s_opex_op1_o),
      .s_opex_op2_o     (s_opex_op2_o),
      .s_opex_rd_o      (s_opex_rd_o),
      .s_opex_f_o       (s_opex_f_o),
      .s_opex_ictrl_o   (s_opex_ictrl_o),
      .s_opex_payload_o (s_opex_payload_o),
      .s_opex_fwd_o     (s_opex_fwd_o),
      .s_idop_hold_o    (s_idop_hold_o),
      .s_stall_cnt_o    (s_stall_cnt_o),
      .s_par_err_o      (s_par_err_o)
   );

   always #5 s_clk_i = ~s_clk_i;

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  fwd;
      logic        bub;
      logic [4:0]  rd;
      logic [3:0]  f;
      logic [6:0]  ictrl;
      logic [20:0] pay;
      logic [31:0] exma;
      logic [31:0] mawb;
      logic        stall;
      logic        flush;
      logic        chk_data;
      logic [31:0] e_op1;
      logic [31:0] e_op2;
      logic [4:0]  e_rd;
      logic [3:0]  e_f;
      logic [6:0]  e_ictrl;
      logic [20:0] e_pay;
      logic [3:0]  e_fwd;
      logic        e_hold;
      logic [7:0]  e_cnt;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      s_idop_op1_i     = v.op1;
      s_idop_op2_i     = v.op2;
      s_idop_fwd_i     = v.fwd;
      s_idop_bubble_i  = v.bub;
      s_idop_rd_i      = v.rd;
      s_idop_f_i       = v.f;
      s_idop_ictrl_i   = v.ictrl;
      s_idop_payload_i = v.pay;
      s_exma_val_i     = v.exma;
      s_mawb_val_i     = v.mawb;
      s_ex_stall_i     = v.stall;
      s_flush_i        = v.flush;
   endtask

   // Inputs are applied 1 time unit after a rising edge; hold is checked
   // before the next edge, registered outputs 1 unit after it.
   task automatic apply(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("v%0d", idx);
      drive(v);
      #1;
      chk({tag, ".hold"}, 32'(s_idop_hold_o), 32'(v.e_hold));
      @(posedge s_clk_i);
      #1;
      chk({tag, ".ictrl"}, 32'(s_opex_ictrl_o), 32'(v.e_ictrl));
      chk({tag, ".rd"},    32'(s_opex_rd_o),    32'(v.e_rd));
      chk({tag, ".fwd"},   32'(s_opex_fwd_o),   32'(v.e_fwd));
      chk({tag, ".cnt"},   32'(s_stall_cnt_o),  32'(v.e_cnt));
      chk({tag, ".par"},   32'(s_par_err_o),    32'd0);
      if (v.chk_data) begin
         chk({tag, ".op1"}, s_opex_op1_o,           v.e_op1);
         chk({tag, ".op2"}, s_opex_op2_o,           v.e_op2);
         chk({tag, ".f"},   32'(s_opex_f_o),        32'(v.e_f));
         chk({tag, ".pay"}, 32'(s_opex_payload_o),  32'(v.e_pay));
      end
   endtask

   vec_t idle;
   vec_t stall_v;
   vec_t load_v;

   initial begin
      //            op1        op2        fwd   bub rd  f     ictrl  pay        exma       mawb       stl fl chk  e_op1      e_op2      e_rd e_f   e_ictrl e_pay      e_fwd hold cnt
      // plain load
      vecs[0]  = '{32'h11,     32'h22,     4'h0, 0, 5,  4'h3, 7'h01, 21'h1ABCD, 32'h0,     32'h0,     0, 0, 1, 32'h11,    32'h22,    5,  4'h3, 7'h01, 21'h1ABCD, 4'h0, 0, 8'd0};
      // bubble: slot empties, OP holds
      vecs[1]  = '{32'h33,     32'h44,     4'hF, 1, 9,  4'h2, 7'h7F, 21'h00001, 32'h0,     32'h0,     0, 0, 0, 32'h0,     32'h0,     0,  4'h0, 7'h00, 21'h0,     4'h0, 1, 8'd0};
      // load with fwd 0101: op1 from MA (A beats B)
      vecs[2]  = '{32'h100,    32'h200,    4'h5, 0, 7,  4'h5, 7'h12, 21'h00055, 32'hA,     32'hB,     0, 0, 1, 32'hA,     32'h200,   7,  4'h5, 7'h12, 21'h00055, 4'h5, 0, 8'd0};
      // stall: capture MA value, flags clear, counter 1
      vecs[3]  = '{32'hDEAD0000,32'hFFFF,  4'hF, 0, 1,  4'h9, 7'h33, 21'h0F0F0, 32'hA,     32'hB,     1, 0, 1, 32'hA,     32'h200,   7,  4'h5, 7'h12, 21'h00055, 4'h0, 1, 8'd1};
      // stall with MA changed: captured value kept
      vecs[4]  = '{32'h0,      32'h0,      4'h0, 0, 0,  4'h0, 7'h00, 21'h0,     32'h77,    32'h88,    1, 0, 1, 32'hA,     32'h200,   7,  4'h5, 7'h12, 21'h00055, 4'h0, 1, 8'd2};
      // load with fwd 1000: op2 from WB, counter clears
      vecs[5]  = '{32'h5,      32'h6,      4'h8, 0, 3,  4'h1, 7'h40, 21'h100000,32'h1,     32'hCAFE,  0, 0, 1, 32'h5,     32'hCAFE,  3,  4'h1, 7'h40, 21'h100000,4'h8, 0, 8'd0};
      // stall: capture WB into op2
      vecs[6]  = '{32'h0,      32'h0,      4'h0, 0, 0,  4'h0, 7'h00, 21'h0,     32'h99,    32'hCAFE,  1, 0, 1, 32'h5,     32'hCAFE,  3,  4'h1, 7'h40, 21'h100000,4'h0, 1, 8'd1};
      vecs[7]  = '{32'h0,      32'h0,      4'h0, 0, 0,  4'h0, 7'h00, 21'h0,     32'h99,    32'h1234,  1, 0, 1, 32'h5,     32'hCAFE,  3,  4'h1, 7'h40, 21'h100000,4'h0, 1, 8'd2};
      // flush during stall
      vecs[8]  = '{32'h0,      32'h0,      4'h0, 0, 0,  4'h0, 7'h00, 21'h0,     32'h0,     32'h0,     1, 1, 0, 32'h0,     32'h0,     0,  4'h0, 7'h00, 21'h0,     4'h0, 0, 8'd0};
      // stall on empty slot: counter does not move
      vecs[9]  = '{32'h0,      32'h0,      4'h0, 0, 0,  4'h0, 7'h00, 21'h0,     32'h0,     32'h0,     1, 0, 0, 32'h0,     32'h0,     0,  4'h0, 7'h00, 21'h0,     4'h0, 1, 8'd0};
      // bubble with flush: hold low
      vecs[10] = '{32'h1,      32'h1,      4'h3, 1, 4,  4'h1, 7'h11, 21'h1,     32'h0,     32'h0,     0, 1, 0, 32'h0,     32'h0,     0,  4'h0, 7'h00, 21'h0,     4'h0, 0, 8'd0};
      // load with fwd 0011: both operands from MA
      vecs[11] = '{32'h1,      32'h2,      4'h3, 0, 31, 4'hF, 7'h01, 21'h1FFFFF,32'hEE,    32'hDD,    0, 0, 1, 32'hEE,    32'hEE,    31, 4'hF, 7'h01, 21'h1FFFFF,4'h3, 0, 8'd0};
      vecs[12] = '{32'h0,      32'h0,      4'h0, 0, 0,  4'h0, 7'h00, 21'h0,     32'hEE,    32'hDD,    1, 0, 1, 32'hEE,    32'hEE,    31, 4'hF, 7'h01, 21'h1FFFFF,4'h0, 1, 8'd1};
      vecs[13] = '{32'h0,      32'h0,      4'h0, 0, 0,  4'h0, 7'h00, 21'h0,     32'h0,     32'h0,     1, 0, 1, 32'hEE,    32'hEE,    31, 4'hF, 7'h01, 21'h1FFFFF,4'h0, 1, 8'd2};

      idle    = vecs[9];
      idle.stall = 1'b0;
      stall_v = vecs[13];

      // Reset state
      s_resetn_i = 1'b0;
      drive(idle);
      repeat (2) @(posedge s_clk_i);
      #1;
      chk("rst.op1",   s_opex_op1_o,             32'd0);
      chk("rst.op2",   s_opex_op2_o,             32'd0);
      chk("rst.ictrl", 32'(s_opex_ictrl_o),      32'd0);
      chk("rst.rd",    32'(s_opex_rd_o),         32'd0);
      chk("rst.f",     32'(s_opex_f_o),          32'd0);
      chk("rst.pay",   32'(s_opex_payload_o),    32'd0);
      chk("rst.fwd",   32'(s_opex_fwd_o),        32'd0);
      chk("rst.cnt",   32'(s_stall_cnt_o),       32'd0);
      chk("rst.par",   32'(s_par_err_o),         32'd0);
      chk("rst.hold",  32'(s_idop_hold_o),       32'd0);
      #3 s_resetn_i = 1'b1;
      @(posedge s_clk_i);
      #1;

      for (int i = 0; i < NVEC; i++) begin
         apply(vecs[i], i);
      end

      // Long stall on a live slot: counter saturates at 255.
      drive(stall_v);
      for (int n = 3; n <= 260; n++) begin
         @(posedge s_clk_i);
         #1;
         if (n == 254) chk("sat.254", 32'(s_stall_cnt_o), 32'd254);
         if (n == 255) chk("sat.255", 32'(s_stall_cnt_o), 32'd255);
         if (n == 260) chk("sat.260", 32'(s_stall_cnt_o), 32'd255);
      end
      chk("sat.op1", s_opex_op1_o, 32'hEE);
      drive(idle);
      @(posedge s_clk_i);
      #1;
      chk("sat.clr", 32'(s_stall_cnt_o), 32'd0);

      // Reset asserted in the middle of a stall discards the instruction.
      apply(vecs[0], 100);
      drive(stall_v);
      @(posedge s_clk_i);
      #1;
      chk("rstmid.cnt1", 32'(s_stall_cnt_o), 32'd1);
      #2 s_resetn_i = 1'b0;
      #1;
      chk("rstmid.ictrl", 32'(s_opex_ictrl_o), 32'd0);
      chk("rstmid.op1",   s_opex_op1_o,        32'd0);
      chk("rstmid.rd",    32'(s_opex_rd_o),    32'd0);
      chk("rstmid.cnt",   32'(s_stall_cnt_o),  32'd0);
      @(posedge s_clk_i);
      #3 s_resetn_i = 1'b1;
      @(posedge s_clk_i);
      #1;
      load_v = vecs[0];
      apply(load_v, 101);

      // Parity error reporting on a live slot.
`ifdef OPEX_PARITY_EN
      force dut.op1_q = 32'h10;
      #1;
      chk("par.flip", 32'(s_par_err_o), 32'd1);
      release dut.op1_q;
      drive(idle);
      @(posedge s_clk_i);
      #1;
      chk("par.clear", 32'(s_par_err_o), 32'd0);
`else
      drive(idle);
      repeat (3) begin
         @(posedge s_clk_i);
         #1;
         chk("par.off", 32'(s_par_err_o), 32'd0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
